// File: rtl/dram_ctrl_pkg.sv
// Shared types for the DRAM controller front end: FSM state encoding and id width helper.
// Pure declarations, no logic or timing.
package dram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    BUSY    = 2'b10,
    REFRESH = 2'b11
  } state_t;

  // Width of an id field able to index n items (BW/RW/CW); never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_rr_arbiter.sv
// Combinational round-robin pick: first asserted req_val at or after rr_ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to act on the winner.
module dram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req_val,
  input  logic [PW-1:0]      rr_ptr,
  output logic [PW-1:0]      winner,
  output logic               any_req
);

  always_comb begin
    int          idx;
    logic [PW-1:0] idx_p;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_p   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PW'(idx);
      if (!any_req && req_val[idx_p]) begin
        any_req = 1'b1;
        winner  = idx_p;
      end
    end
  end

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Round-robin access arbiter plus refresh scheduler in front of dram_ctrl_fsm.
// Grant one cycle after sampling; requesters hold req_val until granted, controller paces via ctrl_done/refresh_ack.
module dram_refresh_arbiter
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int NUMBER_OF_BANKS  = 8,
  parameter int NUMBER_OF_ROWS   = 128,
  parameter int NUMBER_OF_COLS   = 8,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int MAX_POSTPONE     = 8,
  localparam int BW = id_w(NUMBER_OF_BANKS),
  localparam int RW = id_w(NUMBER_OF_ROWS),
  localparam int CW = id_w(NUMBER_OF_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_val,
  input  logic [NUM_REQ*BW-1:0] req_bank,
  input  logic [NUM_REQ*RW-1:0] req_row,
  input  logic [NUM_REQ*CW-1:0] req_col,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic                  ctrl_addr_val,
  output logic [BW-1:0]         ctrl_bank_id,
  output logic [RW-1:0]         ctrl_row_id,
  output logic [CW-1:0]         ctrl_col_id,
  input  logic                  ctrl_done,
  output logic                  refresh_flag,
  input  logic                  refresh_ack,
  output logic [3:0]            refresh_pending,
  output logic                  refresh_overflow
);

  localparam int PW = id_w(NUM_REQ);
  localparam int TW = id_w(REFRESH_INTERVAL);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    PEND_MAX     = 4'(MAX_POSTPONE);
  localparam logic [PW-1:0] LAST_REQ     = PW'(NUM_REQ - 1);

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic          any_req;
  logic [TW-1:0] timer;
  logic          tick;
  logic          ack_eff;
  logic          at_max;

  dram_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_arbiter (
    .req_val (req_val),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign tick    = (timer == '0);
  // An ack only counts against an outstanding refresh request.
  assign ack_eff = refresh_ack && refresh_flag;
  assign at_max  = (refresh_pending == PEND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= TIMER_RELOAD;
    end else if (tick) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_pending  <= 4'd0;
      refresh_overflow <= 1'b0;
    end else if (tick && !ack_eff) begin
      if (at_max) begin
        refresh_overflow <= 1'b1;
      end else begin
        refresh_pending <= refresh_pending + 4'd1;
      end
    end else if (!tick && ack_eff && refresh_pending != 4'd0) begin
      refresh_pending <= refresh_pending - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      req_grant     <= '0;
      ctrl_addr_val <= 1'b0;
      ctrl_bank_id  <= '0;
      ctrl_row_id   <= '0;
      ctrl_col_id   <= '0;
      refresh_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Refresh wins when nobody is waiting or postponing any longer would lose a tick.
          if (refresh_pending != 4'd0 && (!any_req || at_max)) begin
            state        <= REFRESH;
            refresh_flag <= 1'b1;
          end else if (any_req) begin
            state         <= GRANT;
            refresh_flag  <= 1'b0;
            req_grant     <= NUM_REQ'(1) << winner;
            ctrl_addr_val <= 1'b1;
            ctrl_bank_id  <= req_bank[winner*BW +: BW];
            ctrl_row_id   <= req_row[winner*RW +: RW];
            ctrl_col_id   <= req_col[winner*CW +: CW];
            rr_ptr        <= (winner == LAST_REQ) ? '0 : winner + PW'(1);
          end else begin
            refresh_flag <= 1'b0;
          end
        end
        GRANT: begin
          req_grant     <= '0;
          ctrl_addr_val <= 1'b0;
          state         <= BUSY;
        end
        BUSY: begin
          if (ack_eff) begin
            refresh_flag <= 1'b0;
          end else if (at_max) begin
            refresh_flag <= 1'b1;
          end
          if (ctrl_done) begin
            state <= IDLE;
          end
        end
        REFRESH: begin
          if (ack_eff) begin
            refresh_flag <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
